// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU has fixed priority,
// bounded by a starvation counter; DMA can lock the memory for bursts.
module dmem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic              dma_lock,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              locked
);

   localparam int                CNT_W    = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic {ARB, LOCKED} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_starve_cnt, w_starve_nxt;
   logic                w_cpu_gnt, w_dma_gnt;
   logic                r_cpu_rd, r_dma_rd;
   logic [DATA_W-1:0]   r_cpu_rdata, r_dma_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ARB;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   always_comb begin
      w_cpu_gnt    = 1'b0;
      w_dma_gnt    = 1'b0;
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve_cnt;
      case (r_state)
         ARB: begin
            if (cpu_req && dma_req) begin
               if (r_starve_cnt == STARVE_LIM) begin
                  w_dma_gnt = 1'b1;
               end else begin
                  w_cpu_gnt    = 1'b1;
                  w_starve_nxt = r_starve_cnt + CNT_W'(1);
               end
            end else if (cpu_req) begin
               w_cpu_gnt = 1'b1;
            end else if (dma_req) begin
               w_dma_gnt = 1'b1;
            end
            // The counter only measures an unbroken run of DMA waiting.
            if (!dma_req || w_dma_gnt) w_starve_nxt = '0;
            if (w_dma_gnt && dma_lock) w_state_nxt = LOCKED;
         end
         LOCKED: begin
            w_starve_nxt = '0;
            if (dma_req) begin
               w_dma_gnt = 1'b1;
               if (!dma_lock) w_state_nxt = ARB;
            end
         end
         default: begin
            w_state_nxt  = ARB;
            w_starve_nxt = '0;
         end
      endcase
      // Grants are combinational; suppress them while reset is held.
      if (reset) begin
         w_cpu_gnt = 1'b0;
         w_dma_gnt = 1'b0;
      end
   end

   assign cpu_gnt   = w_cpu_gnt;
   assign dma_gnt   = w_dma_gnt;
   assign mem_read  = (w_cpu_gnt & ~cpu_we) | (w_dma_gnt & ~dma_we);
   assign mem_write = (w_cpu_gnt &  cpu_we) | (w_dma_gnt &  dma_we);
   assign mem_addr  = w_dma_gnt ? dma_addr  : (w_cpu_gnt ? cpu_addr  : '0);
   assign mem_wdata = w_dma_gnt ? dma_wdata : (w_cpu_gnt ? cpu_wdata : '0);
   assign locked    = (r_state == LOCKED);

   // Read owner tracked per grant, so reads pipeline back-to-back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpu_rd    <= 1'b0;
         r_dma_rd    <= 1'b0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_cpu_rd <= w_cpu_gnt & ~cpu_we;
         r_dma_rd <= w_dma_gnt & ~dma_we;
         if (r_cpu_rd) r_cpu_rdata <= mem_rdata;
         if (r_dma_rd) r_dma_rdata <= mem_rdata;
      end
   end

   assign cpu_rvalid = r_cpu_rd;
   assign dma_rvalid = r_dma_rd;
   assign cpu_rdata  = r_cpu_rd ? mem_rdata : r_cpu_rdata;
   assign dma_rdata  = r_dma_rd ? mem_rdata : r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, read-data scoreboard per port,
// and one task per scenario with inline grant/command checks.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
   logic [7:0] dma_addr, dma_wdata, dma_rdata;
   logic       mem_read, mem_write, locked;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] mem     [256];
   logic [7:0] exp_mem [256];
   logic [7:0] cpu_q[$];
   logic [7:0] dma_q[$];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .locked(locked)
   );

   // Single-port memory with registered read data.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata     <= mem[mem_addr];
   end

   always @(posedge reset) begin
      cpu_q.delete();
      dma_q.delete();
   end

   // Scoreboard: retire returns first, then record this cycle's grants.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!reset) begin
         if (cpu_rvalid) begin
            vectors++;
            if (cpu_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_cpu: unexpected rvalid, rdata=%h", cpu_rdata);
            end else begin
               e = cpu_q.pop_front();
               if (cpu_rdata !== e) begin
                  miscompares++;
                  $display("FAIL sb_cpu: got %h want %h", cpu_rdata, e);
               end
            end
         end
         if (dma_rvalid) begin
            vectors++;
            if (dma_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_dma: unexpected rvalid, rdata=%h", dma_rdata);
            end else begin
               e = dma_q.pop_front();
               if (dma_rdata !== e) begin
                  miscompares++;
                  $display("FAIL sb_dma: got %h want %h", dma_rdata, e);
               end
            end
         end
         if (cpu_gnt) begin
            if (cpu_we) exp_mem[cpu_addr] = cpu_wdata;
            else        cpu_q.push_back(exp_mem[cpu_addr]);
         end
         if (dma_gnt) begin
            if (dma_we) exp_mem[dma_addr] = dma_wdata;
            else        dma_q.push_back(exp_mem[dma_addr]);
         end
      end
   end

   task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dma(input logic req, input logic we, input logic lk, input logic [7:0] a,
                          input logic [7:0] d);
      dma_req = req; dma_we = we; dma_lock = lk; dma_addr = a; dma_wdata = d;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_read, mem_write, locked} !== 7'b0 ||
          {cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: ctl=%b data=%h want all 0",
                  {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_read, mem_write, locked},
                  {cpu_rdata, dma_rdata, mem_addr, mem_wdata});
      end
      next_cycle();
      reset = 1'b0;
      // A read granted, then reset before the memory edge.
      set_cpu(1, 0, 8'h10, 8'h00);
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pre_gnt: cpu_gnt=%b want 1", cpu_gnt);
      end
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({cpu_gnt, cpu_rvalid, mem_read, locked} !== 4'b0 || cpu_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_read: gnt/rvalid/rd/lock=%b rdata=%h want 0",
                     {cpu_gnt, cpu_rvalid, mem_read, locked}, cpu_rdata);
         end
      end
      set_cpu(0, 0, 8'h00, 8'h00);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (cpu_rvalid !== 1'b0 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_after: cpu_rvalid=%b locked=%b want 0 0", cpu_rvalid, locked);
      end
      next_cycle();
   endtask

   task automatic test_idle();
      set_cpu(0, 0, 8'h00, 8'h00);
      set_dma(0, 0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({cpu_gnt, dma_gnt, mem_read, mem_write} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle: gnt_c/gnt_d/rd/wr=%b want 0000",
                     {cpu_gnt, dma_gnt, mem_read, mem_write});
         end
         next_cycle();
      end
   endtask

   task automatic test_cpu_only();
      set_cpu(1, 1, 8'h10, 8'h5A);
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
          mem_addr !== 8'h10 || mem_wdata !== 8'h5A) begin
         miscompares++;
         $display("FAIL cpu_write: gnt=%b wr=%b rd=%b addr=%h wdata=%h want 1 1 0 10 5a",
                  cpu_gnt, mem_write, mem_read, mem_addr, mem_wdata);
      end
      next_cycle();
      set_cpu(1, 0, 8'h10, 8'h00);
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || cpu_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL cpu_read_cmd: gnt=%b rd=%b wr=%b rvalid=%b want 1 1 0 0",
                  cpu_gnt, mem_read, mem_write, cpu_rvalid);
      end
      next_cycle();
      set_cpu(0, 0, 8'h00, 8'h00);
      @(negedge clk);
      vectors++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin
         miscompares++;
         $display("FAIL cpu_read_ret: rvalid=%b rdata=%h want 1 5a", cpu_rvalid, cpu_rdata);
      end
      next_cycle();
   endtask

   task automatic test_contention();
      logic want_d;
      set_cpu(1, 0, 8'h11, 8'h00);
      set_dma(1, 0, 0, 8'h21, 8'h00);
      for (int i = 0; i < 10; i++) begin
         want_d = (i % 5 == 4);
         @(negedge clk);
         vectors++;
         if (cpu_gnt !== !want_d || dma_gnt !== want_d) begin
            miscompares++;
            $display("FAIL contention[%0d]: cpu_gnt=%b dma_gnt=%b want %b %b",
                     i, cpu_gnt, dma_gnt, !want_d, want_d);
         end
         next_cycle();
      end
      set_cpu(0, 0, 8'h00, 8'h00);
      set_dma(0, 0, 0, 8'h00, 8'h00);
      next_cycle();
   endtask

   task automatic test_burst();
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            set_dma(0, 0, 0, 8'h00, 8'h00);
            set_cpu(1, 0, 8'h30, 8'h00);
            @(negedge clk);
            vectors++;
            if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || locked !== 1'b1) begin
               miscompares++;
               $display("FAIL burst_gap: cpu_gnt=%b dma_gnt=%b locked=%b want 0 0 1",
                        cpu_gnt, dma_gnt, locked);
            end
            next_cycle();
         end
         set_cpu(b != 0, 0, 8'h30, 8'h00);
         set_dma(1, 1, b < 3, 8'h20 + 8'(b), 8'hB0 + 8'(b));
         @(negedge clk);
         vectors++;
         if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_write !== 1'b1 ||
             mem_addr !== 8'h20 + 8'(b) || locked !== (b != 0)) begin
            miscompares++;
            $display("FAIL burst_beat[%0d]: dma_gnt=%b cpu_gnt=%b wr=%b addr=%h locked=%b",
                     b, dma_gnt, cpu_gnt, mem_write, mem_addr, locked);
         end
         next_cycle();
      end
      set_dma(0, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      vectors++;
      if (locked !== 1'b0 || cpu_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL burst_release: locked=%b cpu_gnt=%b want 0 1", locked, cpu_gnt);
      end
      next_cycle();
      set_cpu(0, 0, 8'h00, 8'h00);
      next_cycle();
   endtask

   task automatic test_interleave();
      set_cpu(1, 0, 8'h10, 8'h00);
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL il_cpu_gnt: cpu_gnt=%b want 1", cpu_gnt);
      end
      next_cycle();
      set_cpu(0, 0, 8'h00, 8'h00);
      set_dma(1, 0, 0, 8'h20, 8'h00);
      @(negedge clk);
      vectors++;
      if (dma_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A || dma_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL il_cpu_ret: dma_gnt=%b cpu_rvalid=%b cpu_rdata=%h dma_rvalid=%b want 1 1 5a 0",
                  dma_gnt, cpu_rvalid, cpu_rdata, dma_rvalid);
      end
      next_cycle();
      set_dma(0, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      vectors++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hB0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A) begin
         miscompares++;
         $display("FAIL il_dma_ret: dma_rvalid=%b dma_rdata=%h cpu_rvalid=%b cpu_rdata=%h want 1 b0 0 5a",
                  dma_rvalid, dma_rdata, cpu_rvalid, cpu_rdata);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      set_dma(1, 1, 0, 8'h40, 8'hC3);
      next_cycle();
      set_dma(0, 0, 0, 8'h00, 8'h00);
      set_cpu(1, 0, 8'h40, 8'h00);
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== 1'b1 || mem_read !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_read_cmd: cpu_gnt=%b rd=%b want 1 1", cpu_gnt, mem_read);
      end
      next_cycle();
      set_cpu(0, 0, 8'h00, 8'h00);
      @(negedge clk);
      vectors++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hC3) begin
         miscompares++;
         $display("FAIL b2b_read_ret: rvalid=%b rdata=%h want 1 c3", cpu_rvalid, cpu_rdata);
      end
      next_cycle();
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'(i) ^ 8'hA5;
         exp_mem[i] = 8'(i) ^ 8'hA5;
      end
      reset = 1'b1;
      set_cpu(0, 0, 8'h00, 8'h00);
      set_dma(0, 0, 0, 8'h00, 8'h00);
      #1;
      test_reset();
      test_idle();
      test_cpu_only();
      test_contention();
      test_burst();
      test_interleave();
      test_back_to_back();
      vectors++;
      if (cpu_q.size() != 0 || dma_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: outstanding cpu=%0d dma=%0d want 0 0", cpu_q.size(), dma_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
